im_loader: RTL and testbench

Instruction-memory loader for the pipelined MIPS core. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the instruction memory write port at word-aligned byte addresses. The address scheme matches the memory read side, so address bits [9:2] select the word. The loader holds the processor stalled until a complete program image has been written, which makes program loading synthesizable without a file-based initial image.

---
 rtl/im_loader_if.sv | 28 ++
 rtl/im_loader.sv | 154 +++++++++++++++
 tb/tb_im_loader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader; the master modport is the stream source and memory side.
interface im_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_address;
    logic [31:0] wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_address,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_address,
        output wr_data
    );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream into big-endian words,
// writes them to word-aligned addresses and holds the CPU until the image is complete.
module im_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] ADDR_BASE = 32'd0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    im_loader_if.slave   bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         error,
    output logic [8:0]   words_loaded
);

    localparam logic [15:0] DEPTH_LEN = 16'(DEPTH);
    localparam logic [8:0]  DEPTH_CNT = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_FLUSH  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t      state_r;
    state_t      next_s;
    logic        accept_s;
    logic        last_word_s;
    logic [15:0] len_full_s;

    logic [7:0]  len_hi_r;
    logic [15:0] len_r;
    logic [23:0] asm_r;
    logic [1:0]  byte_cnt_r;
    logic [8:0]  word_index_r;
    logic [8:0]  words_loaded_r;
    logic        in_ready_r;
    logic        wr_en_r;
    logic [31:0] wr_address_r;
    logic [31:0] wr_data_r;
    logic        cpu_hold_r;
    logic        done_r;
    logic        error_r;

    // Next-state decode; in_ready_r already mirrors the current state so it gates acceptance.
    always_comb begin
        next_s      = state_r;
        accept_s    = bus.in_valid && in_ready_r;
        len_full_s  = {len_hi_r, bus.in_data};
        last_word_s = (({7'd0, words_loaded_r} + 16'd1) == len_r);
        case (state_r)
            S_IDLE: begin
                if (start) next_s = S_LEN_HI;
                else       next_s = S_IDLE;
            end
            S_LEN_HI: begin
                if (accept_s) next_s = S_LEN_LO;
                else          next_s = S_LEN_HI;
            end
            S_LEN_LO: begin
                if (!accept_s)                   next_s = S_LEN_LO;
                else if (len_full_s == 16'd0)    next_s = S_DONE;
                else if (len_full_s > DEPTH_LEN) next_s = S_ERR;
                else                             next_s = S_DATA;
            end
            S_DATA: begin
                // The extra flush cycle lets the final write commit before done releases the CPU.
                if (accept_s && (byte_cnt_r == 2'd3) && last_word_s) next_s = S_FLUSH;
                else                                                 next_s = S_DATA;
            end
            S_FLUSH: begin
                next_s = S_DONE;
            end
            S_DONE, S_ERR: begin
                if (start) next_s = S_LEN_HI;
                else       next_s = state_r;
            end
            default: begin
                next_s = S_IDLE;
            end
        endcase
    end

    // State register, registered status outputs and word assembly datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_IDLE;
            len_hi_r       <= 8'd0;
            len_r          <= 16'd0;
            asm_r          <= 24'd0;
            byte_cnt_r     <= 2'd0;
            word_index_r   <= 9'd0;
            words_loaded_r <= 9'd0;
            in_ready_r     <= 1'b0;
            wr_en_r        <= 1'b0;
            wr_address_r   <= 32'd0;
            wr_data_r      <= 32'd0;
            cpu_hold_r     <= 1'b1;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            state_r    <= next_s;
            in_ready_r <= (next_s == S_LEN_HI) || (next_s == S_LEN_LO) || (next_s == S_DATA);
            cpu_hold_r <= (next_s != S_DONE);
            done_r     <= (next_s == S_DONE);
            error_r    <= (next_s == S_ERR);
            wr_en_r    <= 1'b0;

            if ((state_r != S_LEN_HI) && (next_s == S_LEN_HI)) begin
                words_loaded_r <= 9'd0;
            end

            if ((state_r == S_LEN_HI) && accept_s) begin
                len_hi_r <= bus.in_data;
            end

            if ((state_r == S_LEN_LO) && accept_s) begin
                len_r          <= len_full_s;
                byte_cnt_r     <= 2'd0;
                word_index_r   <= 9'd0;
                words_loaded_r <= 9'd0;
            end

            if ((state_r == S_DATA) && accept_s) begin
                asm_r      <= {asm_r[15:0], bus.in_data};
                byte_cnt_r <= byte_cnt_r + 2'd1;
                if (byte_cnt_r == 2'd3) begin
                    wr_en_r      <= 1'b1;
                    wr_data_r    <= {asm_r, bus.in_data};
                    wr_address_r <= ADDR_BASE + {21'd0, word_index_r, 2'b00};
                    word_index_r <= word_index_r + 9'd1;
                    if (words_loaded_r != DEPTH_CNT) begin
                        words_loaded_r <= words_loaded_r + 9'd1;
                    end
                end
            end
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_address = wr_address_r;
    assign bus.wr_data    = wr_data_r;
    assign cpu_hold       = cpu_hold_r;
    assign done           = done_r;
    assign error          = error_r;
    assign words_loaded   = words_loaded_r;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: random byte streams compared against a word-list model.
module tb_im_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [8:0] words_loaded;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] obs_q[$];
    int          obs_t[$];
    logic [7:0]  data_q[$];
    logic [63:0] exp_q[$];

    im_loader_if bus ();

    im_loader #(.DEPTH(256), .ADDR_BASE(32'd0)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: records every memory write with its cycle number.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            obs_q.push_back({bus.wr_address, bus.wr_data});
            obs_t.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   waited;
        logic ok;
        waited = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_byte: in_ready=%b after %0d cycles, required 1", ok, waited);
        end
    endtask

    // Expected writes: word i is bytes 4i..4i+3 big-endian at byte address 4i.
    task automatic build_model(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({32'(4 * i), data_q[4*i], data_q[4*i+1], data_q[4*i+2], data_q[4*i+3]});
        end
    endtask

    task automatic random_data(input int nbytes);
        data_q.delete();
        for (int i = 0; i < nbytes; i++) data_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (3) tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); end
        total++; if (bus.wr_address !== 32'd0) begin bad++; $display("FAIL rst_wr_address: got %h want 0", bus.wr_address); end
        total++; if (bus.wr_data !== 32'd0) begin bad++; $display("FAIL rst_wr_data: got %h want 0", bus.wr_data); end
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", error); end
        total++; if (words_loaded !== 9'd0) begin bad++; $display("FAIL rst_words_loaded: got %0d want 0", words_loaded); end
        reset = 1'b0;
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready: got %b want 0", bus.in_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] b [8];
        b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        obs_q.delete();
        obs_t.delete();
        pulse_start();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_len_hi_ready: got %b want 1", bus.in_ready); end
        send_byte(8'h00);
        send_byte(8'h02);
        for (int i = 0; i < 8; i++) send_byte(b[i]);
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL basic_last_wr_en: got %b want 1", bus.wr_en); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_early: got %b want 0", done); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", done); end
        total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL basic_cpu_hold: got %b want 0", cpu_hold); end
        total++; if (words_loaded !== 9'd2) begin bad++; $display("FAIL basic_words_loaded: got %0d want 2", words_loaded); end
        total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL basic_write_count: got %0d want 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            total++; if (obs_q[0] !== {32'h0, 32'h20080005}) begin bad++; $display("FAIL basic_word0: got %h want %h", obs_q[0], {32'h0, 32'h20080005}); end
            total++; if (obs_q[1] !== {32'h4, 32'h8C090004}) begin bad++; $display("FAIL basic_word1: got %h want %h", obs_q[1], {32'h4, 32'h8C090004}); end
            total++; if (obs_t[1] - obs_t[0] !== 4) begin bad++; $display("FAIL basic_throughput: got %0d cycles want 4", obs_t[1] - obs_t[0]); end
        end
    endtask

    task automatic test_zero_len();
        obs_q.delete();
        pulse_start();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_cleared: got %b want 0", done); end
        send_byte(8'h00);
        send_byte(8'h00);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done); end
        total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL zero_cpu_hold: got %b want 0", cpu_hold); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL zero_in_ready: got %b want 0", bus.in_ready); end
        repeat (3) tick();
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL zero_writes: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_error();
        obs_q.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        total++; if (error !== 1'b1) begin bad++; $display("FAIL err_error: got %b want 1", error); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL err_in_ready: got %b want 0", bus.in_ready); end
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL err_cpu_hold: got %b want 1", cpu_hold); end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (4) tick();
        bus.in_valid = 1'b0;
        total++; if (error !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", error); end
        pulse_start();
        total++; if (error !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", error); end
        random_data(4);
        build_model(1);
        send_byte(8'h00);
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(data_q[i]);
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL err_reload_done: got %b want 1", done); end
        total++; if (obs_q.size() !== 1) begin bad++; $display("FAIL err_reload_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() == 1) begin
            total++; if (obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL err_reload_word: got %h want %h", obs_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_full_256();
        obs_q.delete();
        random_data(1024);
        build_model(256);
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < 1024; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(data_q[i]);
        end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done: got %b want 1", done); end
        total++; if (words_loaded !== 9'd256) begin bad++; $display("FAIL full_words_loaded: got %0d want 256", words_loaded); end
        total++; if (obs_q.size() !== 256) begin bad++; $display("FAIL full_write_count: got %0d want 256", obs_q.size()); end
        if (obs_q.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
            total++; if (obs_q[255][63:32] !== 32'h3FC) begin bad++; $display("FAIL full_last_addr: got %h want 3fc", obs_q[255][63:32]); end
        end
    endtask

    task automatic test_reset_mid();
        obs_q.delete();
        random_data(20);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h05);
        for (int i = 0; i < 10; i++) send_byte(data_q[i]);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); end
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL midrst_cpu_hold: got %b want 1", cpu_hold); end
        total++; if (words_loaded !== 9'd0) begin bad++; $display("FAIL midrst_words_loaded: got %0d want 0", words_loaded); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL midrst_wr_en: got %b want 0", bus.wr_en); end
        repeat (3) tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_still_idle: got %b want 0", bus.in_ready); end
        total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL midrst_write_count: got %0d want 2", obs_q.size()); end
        random_data(4);
        build_model(1);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(data_q[i]);
        tick();
        total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL midrst_reload_count: got %0d want 3", obs_q.size()); end
        if (obs_q.size() == 3) begin
            total++; if (obs_q[2] !== exp_q[0]) begin bad++; $display("FAIL midrst_reload_word: got %h want %h", obs_q[2], exp_q[0]); end
        end
    endtask

    task automatic test_ignore_start();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        obs_q.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ign_idle_ready: got %b want 0", bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        random_data(12);
        build_model(3);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h03);
        for (int i = 0; i < 4; i++) send_byte(data_q[i]);
        pulse_start();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ign_data_ready: got %b want 1", bus.in_ready); end
        for (int i = 4; i < 6; i++) send_byte(data_q[i]);
        pulse_start();
        for (int i = 6; i < 12; i++) send_byte(data_q[i]);
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done: got %b want 1", done); end
        total++; if (words_loaded !== 9'd3) begin bad++; $display("FAIL ign_words_loaded: got %0d want 3", words_loaded); end
        total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL ign_write_count: got %0d want 3", obs_q.size()); end
        if (obs_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL ign_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ign_done_ready: got %b want 0", bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done_hold: got %b want 1", done); end
        total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL ign_done_writes: got %0d want 3", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_error();
        test_full_256();
        test_reset_mid();
        test_ignore_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
